stream_checker: RTL and testbench

STREAM_CHECKER -- requirements
Module: stream_checker

---
 rtl/stream_checker_pkg.sv | 20 ++
 rtl/stream_checker_lfsr16.sv | 22 ++
 rtl/stream_checker.sv | 138 +++++++++++++
 tb/tb_stream_checker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_checker_pkg.sv
// Shared types and constants for the stream checker: FSM states and the
// backpressure LFSR definition.
package stream_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

    // One step of a right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/stream_checker_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load; drives the sink backpressure pattern.
module lfsr16
    import stream_checker_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        enable,
    output logic [15:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= LFSR_SEED;
        end else if (load) begin
            value <= LFSR_SEED;
        end else if (enable) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/stream_checker.sv
// Stream sink that applies LFSR-driven backpressure, checks each accepted word
// against an index-derived pattern and reports a pass/fail summary per run.
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned NUM_XFERS     = 16,
    parameter logic [15:0] STALL_MASK    = 16'h0000,
    parameter int unsigned TIMEOUT       = 1024,
    parameter bit          EXPECT_INVERT = 1'b1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             done,
    output logic             pass,
    output logic             timed_out,
    output logic [15:0]      xfer_count,
    output logic [15:0]      err_count,
    output logic [15:0]      first_err_idx
);

    state_t           state;
    state_t           state_next;
    logic [15:0]      lfsr;
    logic [31:0]      idle_count;
    logic             enter_run;
    logic             xfer;
    logic             mismatch;
    logic             last_xfer;
    logic             timeout_hit;
    logic             ready_next;
    logic [WIDTH-1:0] expected;

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .load   (enter_run),
        .enable (state == RUN),
        .value  (lfsr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        enter_run   = 1'b0;
        xfer        = 1'b0;
        mismatch    = 1'b0;
        last_xfer   = 1'b0;
        timeout_hit = 1'b0;
        ready_next  = 1'b0;
        expected    = WIDTH'(xfer_count);
        if (EXPECT_INVERT) begin
            expected = ~expected;
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    enter_run  = 1'b1;
                end
            end
            RUN: begin
                xfer        = i_valid && o_ready;
                mismatch    = xfer && (i_data != expected);
                last_xfer   = xfer && (xfer_count == 16'(NUM_XFERS - 1));
                // A transfer always beats the watchdog in the same cycle.
                timeout_hit = !xfer && (idle_count == TIMEOUT - 1);
                if (last_xfer || timeout_hit) begin
                    state_next = DONE;
                end else begin
                    ready_next = ((lfsr & STALL_MASK) == 16'h0000);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_ready       <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timed_out     <= 1'b0;
            xfer_count    <= '0;
            err_count     <= '0;
            first_err_idx <= NO_ERR_IDX;
            idle_count    <= '0;
        end else begin
            o_ready <= ready_next;
            if (enter_run) begin
                done          <= 1'b0;
                pass          <= 1'b0;
                timed_out     <= 1'b0;
                xfer_count    <= '0;
                err_count     <= '0;
                first_err_idx <= NO_ERR_IDX;
                idle_count    <= '0;
            end else if (state == RUN) begin
                if (xfer) begin
                    xfer_count <= xfer_count + 16'd1;
                    idle_count <= '0;
                end else begin
                    idle_count <= idle_count + 32'd1;
                end
                if (mismatch) begin
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 16'd1;
                    end
                    if (err_count == 16'h0000) begin
                        first_err_idx <= xfer_count;
                    end
                end
                if (last_xfer) begin
                    done <= 1'b1;
                    pass <= (err_count == 16'h0000) && !mismatch;
                end
                if (timeout_hit) begin
                    done      <= 1'b1;
                    timed_out <= 1'b1;
                    pass      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_checker.sv
// Randomized scoreboard bench for stream_checker: a driver runs a reference model
// of each run and queues the expected summary; a monitor checks it when done rises.
module tb_stream_checker;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NUM   = 16;
    localparam int unsigned TMO   = 64;
    localparam logic [15:0] MASK  = 16'h0003;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic        done;
    logic        pass;
    logic        timed_out;
    logic [15:0] xfer_count;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned cyc    = 0;
    bit          done_q = 1'b0;

    typedef struct {
        bit          pass;
        bit          tmo;
        int unsigned xfer;
        int unsigned err;
        int unsigned first;
        int unsigned done_cyc;
    } exp_t;

    exp_t exp_q[$];

    stream_checker #(
        .WIDTH         (WIDTH),
        .NUM_XFERS     (NUM),
        .STALL_MASK    (MASK),
        .TIMEOUT       (TMO),
        .EXPECT_INVERT (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_data        (i_data),
        .done          (done),
        .pass          (pass),
        .timed_out     (timed_out),
        .xfer_count    (xfer_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Galois step written arithmetically: halve, and fold the taps in when odd.
    function automatic logic [15:0] model_step(input logic [15:0] v);
        return (v / 16'd2) ^ ((v % 16'd2 == 16'd1) ? 16'hB400 : 16'h0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_o_ready"},       32'(o_ready),       32'h0);
        check({tag, "_done"},          32'(done),          32'h0);
        check({tag, "_pass"},          32'(pass),          32'h0);
        check({tag, "_timed_out"},     32'(timed_out),     32'h0);
        check({tag, "_xfer_count"},    32'(xfer_count),    32'h0);
        check({tag, "_err_count"},     32'(err_count),     32'h0);
        check({tag, "_first_err_idx"}, 32'(first_err_idx), 32'hFFFF);
    endtask

    // Monitor: compare a queued summary whenever done rises.
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_q) begin
            check("result_expected", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("done_cycle",    cyc,                 e.done_cyc);
                check("pass",          32'(pass),           32'(e.pass));
                check("timed_out",     32'(timed_out),      32'(e.tmo));
                check("xfer_count",    32'(xfer_count),     e.xfer);
                check("err_count",     32'(err_count),      e.err);
                check("first_err_idx", 32'(first_err_idx),  e.first);
            end
        end
        done_q = done;
    end

    // One run: the model decides every transfer from its own ready sequence.
    task automatic do_run(input int unsigned valid_pct, input int corrupt_idx,
                          input int unsigned corrupt_pct, input int abort_after,
                          input int poke_cyc);
        logic [15:0] m_lfsr;
        bit          m_ready;
        bit          fin;
        bit          aborted;
        bit          v;
        int          k;
        int          n;
        int          idle;
        int unsigned errs;
        int unsigned first;
        logic [7:0]  e;
        logic [7:0]  d;
        exp_t        rec;

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        m_lfsr  = 16'hACE1;
        m_ready = 1'b0;
        fin     = 1'b0;
        aborted = 1'b0;
        k       = 0;
        n       = 0;
        idle    = 0;
        errs    = 0;
        first   = 32'hFFFF;
        while (!fin) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (n == 1) begin
                check("run_clear_xfer",  32'(xfer_count),    32'h0);
                check("run_clear_err",   32'(err_count),     32'h0);
                check("run_clear_first", 32'(first_err_idx), 32'hFFFF);
                check("run_clear_done",  32'(done),          32'h0);
            end
            if (n == poke_cyc) start = 1'b1;
            check("o_ready", 32'(o_ready), 32'(m_ready));
            v = ($urandom_range(99) < valid_pct);
            e = ~8'(k);
            d = e;
            if ((corrupt_idx >= 0 && k == corrupt_idx) || ($urandom_range(99) < corrupt_pct))
                d = e ^ 8'h05;
            i_valid = v;
            i_data  = v ? d : 8'($urandom);
            if (v && m_ready) begin
                if (d != e) begin
                    if (errs == 0) first = 32'(k);
                    errs++;
                end
                k++;
                idle = 0;
                if (k == int'(NUM)) begin
                    rec = '{pass: (errs == 0), tmo: 1'b0, xfer: 32'(k), err: errs,
                            first: first, done_cyc: cyc + 1};
                    exp_q.push_back(rec);
                    fin = 1'b1;
                end else if (abort_after > 0 && k == abort_after) begin
                    aborted = 1'b1;
                    fin     = 1'b1;
                end
            end else begin
                idle++;
                if (idle == int'(TMO)) begin
                    rec = '{pass: 1'b0, tmo: 1'b1, xfer: 32'(k), err: errs,
                            first: first, done_cyc: cyc + 1};
                    exp_q.push_back(rec);
                    fin = 1'b1;
                end
            end
            m_ready = ((m_lfsr & MASK) == 16'h0000);
            m_lfsr  = model_step(m_lfsr);
            @(posedge clk);
        end
        @(negedge clk);
        i_valid = 1'b0;
        start   = 1'b0;
        if (aborted) begin
            reset = 1'b1;
            @(negedge clk);
            check_reset_outputs("mid_run_reset");
            reset = 1'b0;
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_o_ready", 32'(o_ready), 32'h0);
        check("idle_done",    32'(done),    32'h0);

        do_run(100, -1, 0, 0, 0);   // clean run, always valid
        do_run(100,  5, 0, 0, 0);   // index 5 carries 0xFF
        do_run(0,   -1, 0, 0, 0);   // never valid: watchdog
        do_run(100, -1, 0, 7, 0);   // reset after 7 transfers
        do_run(100, -1, 0, 0, 0);   // clean run from IDLE after reset
        do_run(75,  -1, 0, 0, 6);   // start pulsed mid-run
        do_run(100, 15, 0, 0, 0);   // final transfer corrupt
        do_run(10,  -1, 0, 0, 0);   // sparse valid, likely mid-run timeout
        for (int i = 0; i < 8; i++)
            do_run($urandom_range(100, 20), -1, $urandom_range(15, 0), 0,
                   int'($urandom_range(30, 0)));

        repeat (5) @(negedge clk);
        check("results_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
